attack_ctrl: RTL and testbench

ATTACK_CTRL -- requirements
Module: attack_ctrl

---
 rtl/game_pkg.sv | 46 ++++
 rtl/atk_timing.sv | 27 ++
 rtl/attack_ctrl.sv | 130 +++++++++++++
 tb/tb_attack_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the attack controller: state encoding, attack codes,
// weapon type codes and per-weapon duration tables (in game ticks).
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WINDUP   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } atk_state_e;

  localparam int CNT_W  = 5;
  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] TYPE_WOODEN = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_BASYS  = 3'd1;
  localparam logic [TYPE_W-1:0] TYPE_CAR    = 3'd2;

  localparam logic [3:0] ATK_NONE  = 4'h0;
  localparam logic [3:0] ATK_BACK  = 4'hA;
  localparam logic [3:0] ATK_FRONT = 4'hB;
  localparam logic [3:0] ATK_LEFT  = 4'hC;
  localparam logic [3:0] ATK_RIGHT = 4'hD;

  localparam logic [CNT_W-1:0] WINDUP_T = 5'd2;

  // Indexed by weapon type: [0] wooden, [1] basys, [2] car.
  localparam logic [2:0][CNT_W-1:0] ACT_T = {5'd10, 5'd6, 5'd8};
  localparam logic [2:0][CNT_W-1:0] CD_T  = {5'd30, 5'd20, 5'd12};

  function automatic logic [3:0] dir2code(input logic [1:0] dir);
    logic [3:0] code;
    case (dir)
      2'd0:    code = ATK_BACK;
      2'd1:    code = ATK_FRONT;
      2'd2:    code = ATK_LEFT;
      default: code = ATK_RIGHT;
    endcase
    return code;
  endfunction

  function automatic logic type_ok(input logic [TYPE_W-1:0] t);
    return t <= TYPE_CAR;
  endfunction

endpackage

// File: rtl/atk_timing.sv
// Combinational duration lookup: active and cooldown lengths for a weapon type.
module atk_timing
  import game_pkg::*;
(
  input  logic [TYPE_W-1:0] type_i,
  output logic [CNT_W-1:0]  act_o,
  output logic [CNT_W-1:0]  cd_o
);

  // Unused codes never reach the register, but fall back to wooden anyway.
  always_comb begin
    act_o = ACT_T[0];
    cd_o  = CD_T[0];
    case (type_i)
      TYPE_BASYS: begin
        act_o = ACT_T[1];
        cd_o  = CD_T[1];
      end
      TYPE_CAR: begin
        act_o = ACT_T[2];
        cd_o  = CD_T[2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/attack_ctrl.sv
// Attack sequencer: IDLE -> WINDUP -> ACTIVE -> COOLDOWN with tick-paced
// down-counter, one-deep request buffer and weapon selection while idle.
module attack_ctrl
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              gameover,
  input  logic              attack_btn,
  input  logic [1:0]        facing,
  input  logic [TYPE_W-1:0] weapon_sel,
  input  logic              sel_valid,
  // "type" is a reserved word, hence the suffix.
  output logic [TYPE_W-1:0] type_o,
  output logic [3:0]        atk_code,
  output logic              busy,
  output logic              pending
);

  atk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dir_q, dir_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [3:0]        atk_q, atk_d;
  logic              pend_q, pend_d;

  logic [CNT_W-1:0]  act_len, cd_len;
  logic              expire;

  atk_timing u_timing (
    .type_i (type_q),
    .act_o  (act_len),
    .cd_o   (cd_len)
  );

  // <= 1 rather than == 1 so a stray zero count cannot wedge a state.
  assign expire = tick && (cnt_q <= 5'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    type_d  = type_q;
    pend_d  = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid && type_ok(weapon_sel)) type_d = weapon_sel;
        if (attack_btn) begin
          dir_d   = facing;
          cnt_d   = WINDUP_T;
          state_d = ST_WINDUP;
        end
      end
      ST_WINDUP: begin
        if (expire) begin
          cnt_d   = act_len;
          state_d = ST_ACTIVE;
        end else if (tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_ACTIVE: begin
        if (attack_btn) pend_d = 1'b1;
        if (expire) begin
          cnt_d   = cd_len;
          state_d = ST_COOLDOWN;
        end else if (tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_COOLDOWN: begin
        if (attack_btn) pend_d = 1'b1;
        // A press landing on the expiry cycle counts as buffered.
        if (expire) begin
          if (pend_q || attack_btn) begin
            pend_d  = 1'b0;
            dir_d   = facing;
            cnt_d   = WINDUP_T;
            state_d = ST_WINDUP;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (gameover) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      dir_d   = dir_q;
      type_d  = type_q;
    end

    atk_d = (state_d == ST_ACTIVE) ? dir2code(dir_d) : ATK_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      type_q  <= TYPE_WOODEN;
      atk_q   <= ATK_NONE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      type_q  <= type_d;
      atk_q   <= atk_d;
      pend_q  <= pend_d;
    end
  end

  assign type_o   = type_q;
  assign atk_code = atk_q;
  assign busy     = (state_q != ST_IDLE);
  assign pending  = pend_q;

endmodule

// File: tb/tb_attack_ctrl.sv
// Directed scenario bench for attack_ctrl; each task drives one scenario and
// checks hand-computed cycle counts and codes.
module tb_attack_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, gameover, attack_btn, sel_valid;
  logic [1:0] facing;
  logic [2:0] weapon_sel;
  logic [2:0] type_w;
  logic [3:0] atk_code;
  logic       busy, pending;

  int errors = 0;
  int checks = 0;

  attack_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .gameover   (gameover),
    .attack_btn (attack_btn),
    .facing     (facing),
    .weapon_sel (weapon_sel),
    .sel_valid  (sel_valid),
    .type_o     (type_w),
    .atk_code   (atk_code),
    .busy       (busy),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; tick = 1'b1; gameover = 1'b0; attack_btn = 1'b0;
    sel_valid = 1'b0; facing = 2'd0; weapon_sel = 3'd0;
    step; step;
    checks++; if (type_w !== 3'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", type_w); end
    checks++; if (atk_code !== 4'h0) begin errors++; $display("FAIL reset_atk: got %0h expected 0", atk_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", pending); end
    rst = 1'b1;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got busy %0b expected 0", busy); end
  endtask

  task automatic test_basic;
    int first_c, n_c, n_other, fall;
    first_c = -1; n_c = 0; n_other = 0; fall = -1;
    facing = 2'd2; attack_btn = 1'b1;
    step;
    attack_btn = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %0b expected 1", busy); end
    checks++; if (atk_code !== 4'h0) begin errors++; $display("FAIL basic_windup_atk: got %0h expected 0", atk_code); end
    for (int k = 2; k <= 40; k++) begin
      step;
      if (atk_code == 4'hC) begin
        n_c++;
        if (first_c < 0) first_c = k;
      end else if (atk_code != 4'h0) n_other++;
      if (!busy && fall < 0) fall = k;
    end
    checks++; if (first_c !== 3) begin errors++; $display("FAIL basic_first_code: got cycle %0d expected 3", first_c); end
    checks++; if (n_c !== 8) begin errors++; $display("FAIL basic_active_len: got %0d expected 8", n_c); end
    checks++; if (n_other !== 0) begin errors++; $display("FAIL basic_bad_codes: got %0d expected 0", n_other); end
    checks++; if (fall !== 23) begin errors++; $display("FAIL basic_busy_fall: got cycle %0d expected 23", fall); end
  endtask

  task automatic test_sel;
    int waited;
    facing = 2'd1; attack_btn = 1'b1;
    step;
    attack_btn = 1'b0;
    step; step;
    checks++; if (atk_code !== 4'hB) begin errors++; $display("FAIL sel_front_code: got %0h expected b", atk_code); end
    for (int k = 4; k <= 11; k++) step;
    sel_valid = 1'b1; weapon_sel = 3'd1;
    step;
    sel_valid = 1'b0;
    checks++; if (type_w !== 3'd0) begin errors++; $display("FAIL sel_in_cooldown: got %0d expected 0", type_w); end
    checks++; if (busy !== 1'b1 || atk_code !== 4'h0) begin errors++; $display("FAIL sel_cooldown_state: got busy %0b atk %0h expected 1 0", busy, atk_code); end
    waited = 0;
    while (busy && waited < 40) begin step; waited++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel_wait_idle: got busy %0b expected 0", busy); end
    sel_valid = 1'b1; weapon_sel = 3'd5;
    step;
    sel_valid = 1'b0;
    step;
    checks++; if (type_w !== 3'd0) begin errors++; $display("FAIL sel_invalid_code: got %0d expected 0", type_w); end
    sel_valid = 1'b1; weapon_sel = 3'd1;
    step;
    sel_valid = 1'b0;
    checks++; if (type_w !== 3'd1) begin errors++; $display("FAIL sel_idle_update: got %0d expected 1", type_w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel_no_start: got busy %0b expected 0", busy); end
  endtask

  task automatic test_slow_tick;
    int n_act, n_cd, k;
    logic seen_act, done;
    n_act = 0; n_cd = 0; k = 0; seen_act = 1'b0; done = 1'b0;
    facing = 2'd2; attack_btn = 1'b1; tick = 1'b0;
    step;
    attack_btn = 1'b0;
    while (!done && k < 400) begin
      k++;
      tick = (k % 4 == 0);
      step;
      if (atk_code == 4'hC) begin
        n_act++;
        seen_act = 1'b1;
      end else if (seen_act && busy) n_cd++;
      if (seen_act && !busy) done = 1'b1;
    end
    tick = 1'b1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL slow_timeout: got done %0b expected 1", done); end
    checks++; if (n_act !== 24) begin errors++; $display("FAIL slow_active_len: got %0d expected 24", n_act); end
    checks++; if (n_cd !== 80) begin errors++; $display("FAIL slow_cooldown_len: got %0d expected 80", n_cd); end
  endtask

  task automatic test_pending;
    int first_a, n_a, first_d, n_d, first_c, n_c, fall;
    first_a = -1; n_a = 0; first_d = -1; n_d = 0; first_c = -1; n_c = 0; fall = -1;
    // Press and select together: car durations govern this sequence.
    facing = 2'd0; attack_btn = 1'b1; sel_valid = 1'b1; weapon_sel = 3'd2;
    step;
    attack_btn = 1'b0; sel_valid = 1'b0; facing = 2'd1;
    checks++; if (type_w !== 3'd2) begin errors++; $display("FAIL pend_type_apply: got %0d expected 2", type_w); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_busy_start: got %0b expected 1", busy); end
    for (int k = 2; k <= 140; k++) begin
      attack_btn = (k == 6 || k == 8 || k == 25 || k == 85);
      if (k == 20) facing = 2'd3;
      if (k == 85) facing = 2'd2;
      step;
      if (k == 6) begin
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_set_active: got %0b expected 1", pending); end
      end
      if (k == 43) begin
        checks++; if (pending !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pend_consumed: got pending %0b busy %0b expected 0 1", pending, busy); end
      end
      if (atk_code == 4'hA) begin n_a++; if (first_a < 0) first_a = k; end
      if (atk_code == 4'hD) begin n_d++; if (first_d < 0) first_d = k; end
      if (atk_code == 4'hC) begin n_c++; if (first_c < 0) first_c = k; end
      if (!busy && fall < 0) fall = k;
    end
    attack_btn = 1'b0;
    checks++; if (first_a !== 3 || n_a !== 10) begin errors++; $display("FAIL pend_burst1: got start %0d len %0d expected 3 10", first_a, n_a); end
    checks++; if (first_d !== 45 || n_d !== 10) begin errors++; $display("FAIL pend_burst2: got start %0d len %0d expected 45 10", first_d, n_d); end
    checks++; if (first_c !== 87 || n_c !== 10) begin errors++; $display("FAIL pend_expiry_press: got start %0d len %0d expected 87 10", first_c, n_c); end
    checks++; if (fall !== 127) begin errors++; $display("FAIL pend_busy_fall: got cycle %0d expected 127", fall); end
  endtask

  task automatic test_gameover;
    int bad;
    bad = 0;
    facing = 2'd3; attack_btn = 1'b1;
    step;
    attack_btn = 1'b0;
    step; step;
    checks++; if (atk_code !== 4'hD) begin errors++; $display("FAIL go_active_code: got %0h expected d", atk_code); end
    attack_btn = 1'b1;
    step;
    attack_btn = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL go_pending_set: got %0b expected 1", pending); end
    step;
    gameover = 1'b1;
    step;
    gameover = 1'b0;
    checks++; if (atk_code !== 4'h0) begin errors++; $display("FAIL go_atk_clear: got %0h expected 0", atk_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL go_busy_clear: got %0b expected 0", busy); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL go_pending_clear: got %0b expected 0", pending); end
    checks++; if (type_w !== 3'd2) begin errors++; $display("FAIL go_type_hold: got %0d expected 2", type_w); end
    for (int k = 0; k < 6; k++) begin
      step;
      if (busy || atk_code != 4'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL go_stays_idle: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    facing = 2'd1; attack_btn = 1'b1;
    step;
    attack_btn = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_windup: got busy %0b expected 1", busy); end
    rst = 1'b0;
    step;
    checks++; if (type_w !== 3'd0 || atk_code !== 4'h0 || busy !== 1'b0 || pending !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: got type %0d atk %0h busy %0b pending %0b expected 0 0 0 0", type_w, atk_code, busy, pending);
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step;
      if (busy || atk_code != 4'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_no_codes: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sel;
    test_slow_tick;
    test_pending;
    test_gameover;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
